versat_databus_arbiter: RTL and testbench

Round-robin arbiter that shares one external databus master port between NUM_REQ Versat memory-mapped units (VRead/VWrite-style, each exposing a databus_*_0 port). It grants one requester at a time and locks the grant for a whole transfer. The grant is released only on the beat the slave flags as last. It sits between the unit databus ports and the single AXI adapter of the accelerator top level.

---
 rtl/versat_databus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_versat_databus_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versat_databus_arbiter.sv
// rtl/versat_databus_arbiter.sv - round-robin databus arbiter, grant locked until the last beat
// Define VERSAT_DATABUS_ARB_BACK_TO_BACK_EN to re-arbitrate on the release beat (no IDLE bubble).
module versat_databus_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int LEN_W      = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   input  logic [NUM_REQ*AXI_ADDR_W-1:0]    req_addr_i,
   input  logic [NUM_REQ*AXI_DATA_W-1:0]    req_wdata_i,
   input  logic [NUM_REQ*AXI_DATA_W/8-1:0]  req_wstrb_i,
   input  logic [NUM_REQ*LEN_W-1:0]         req_len_i,
   input  logic [NUM_REQ-1:0]               req_write_i,
   output logic [AXI_DATA_W-1:0]            req_rdata_o,
   output logic [NUM_REQ-1:0]               req_last_o,
   output logic                             m_valid_o,
   input  logic                             m_ready_i,
   output logic [AXI_ADDR_W-1:0]            m_addr_o,
   output logic [AXI_DATA_W-1:0]            m_wdata_o,
   output logic [AXI_DATA_W/8-1:0]          m_wstrb_o,
   output logic [LEN_W-1:0]                 m_len_o,
   output logic                             m_write_o,
   input  logic [AXI_DATA_W-1:0]            m_rdata_i,
   input  logic                             m_last_i,
   output logic [$clog2(NUM_REQ)-1:0]       grant_o,
   output logic                             busy_o
);

   localparam int GW     = $clog2(NUM_REQ);
   localparam int STRB_W = AXI_DATA_W / 8;
   localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
   localparam logic [GW:0]   NUM_REQ_W = (GW + 1)'(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic [GW-1:0] grant, grant_nxt;
   logic [GW-1:0] rr_ptr, rr_ptr_nxt;
   logic [GW-1:0] grant_inc;
   logic [GW-1:0] search_base;
   logic [GW-1:0] winner;
   logic [GW-1:0] win_off;
   logic          found;
   logic          release_beat;
   logic [2*NUM_REQ-1:0] valid_dbl;
   logic [2*NUM_REQ-1:0] valid_rot_full;
   logic [NUM_REQ-1:0]   valid_rot;
   logic [GW:0]          win_sum;
   logic [GW:0]          win_diff;

   logic [AXI_ADDR_W-1:0] addr_s  [NUM_REQ];
   logic [AXI_DATA_W-1:0] wdata_s [NUM_REQ];
   logic [STRB_W-1:0]     wstrb_s [NUM_REQ];
   logic [LEN_W-1:0]      len_s   [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign addr_s[k]  = req_addr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
      assign wdata_s[k] = req_wdata_i[k*AXI_DATA_W +: AXI_DATA_W];
      assign wstrb_s[k] = req_wstrb_i[k*STRB_W +: STRB_W];
      assign len_s[k]   = req_len_i[k*LEN_W +: LEN_W];
   end

   assign grant_inc = (grant == LAST_IDX) ? '0 : grant + GW'(1);

   // While BUSY the search only matters on a release beat, where it starts past the owner.
   assign search_base = (state == BUSY) ? grant_inc : rr_ptr;

   // Rotate valids so bit 0 is the search base; the lowest set bit is the winner offset.
   assign valid_dbl      = {req_valid_i, req_valid_i};
   assign valid_rot_full = valid_dbl >> search_base;
   assign valid_rot      = valid_rot_full[NUM_REQ-1:0];

   always_comb begin
      found   = 1'b0;
      win_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid_rot[i]) begin
            found   = 1'b1;
            win_off = GW'(i);
         end
      end
   end

   assign win_sum  = {1'b0, search_base} + {1'b0, win_off};
   assign win_diff = win_sum - NUM_REQ_W;
   assign winner   = (win_sum >= NUM_REQ_W) ? win_diff[GW-1:0] : win_sum[GW-1:0];

   always_comb begin
      m_valid_o   = 1'b0;
      m_addr_o    = '0;
      m_wdata_o   = '0;
      m_wstrb_o   = '0;
      m_len_o     = '0;
      m_write_o   = 1'b0;
      req_ready_o = '0;
      req_last_o  = '0;
      if (state == BUSY) begin
         m_valid_o          = req_valid_i[grant];
         m_addr_o           = addr_s[grant];
         m_wdata_o          = wdata_s[grant];
         m_wstrb_o          = wstrb_s[grant];
         m_len_o            = len_s[grant];
         m_write_o          = req_write_i[grant];
         req_ready_o[grant] = m_ready_i;
         req_last_o[grant]  = m_last_i;
      end
   end

   assign req_rdata_o  = m_rdata_i;
   assign release_beat = (state == BUSY) && m_valid_o && m_ready_i && m_last_i;

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt = winner;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (release_beat) begin
               rr_ptr_nxt = grant_inc;
`ifdef VERSAT_DATABUS_ARB_BACK_TO_BACK_EN
               if (found) begin
                  grant_nxt = winner;
                  state_nxt = BUSY;
               end else begin
                  state_nxt = IDLE;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   assign grant_o = grant;
   assign busy_o  = (state == BUSY);

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// tb/tb_versat_databus_arbiter.sv - self-checking bench for versat_databus_arbiter
module tb_versat_databus_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 16;
   localparam int SW = DW / 8;
`ifdef VERSAT_DATABUS_ARB_BACK_TO_BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]  valid, wr;
   logic [AW-1:0] a  [N];
   logic [DW-1:0] wd [N];
   logic [SW-1:0] ws [N];
   logic [LW-1:0] ln [N];
   logic [N*AW-1:0] addr_p;
   logic [N*DW-1:0] wdata_p;
   logic [N*SW-1:0] wstrb_p;
   logic [N*LW-1:0] len_p;
   logic          m_ready, m_last;
   logic [DW-1:0] m_rdata;

   logic [N-1:0]  req_ready_o, req_last_o;
   logic [DW-1:0] req_rdata_o;
   logic          m_valid_o, m_write_o, busy_o;
   logic [AW-1:0] m_addr_o;
   logic [DW-1:0] m_wdata_o;
   logic [SW-1:0] m_wstrb_o;
   logic [LW-1:0] m_len_o;
   logic [1:0]    grant_o;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         addr_p[k*AW +: AW]  = a[k];
         wdata_p[k*DW +: DW] = wd[k];
         wstrb_p[k*SW +: SW] = ws[k];
         len_p[k*LW +: LW]   = ln[k];
      end
   end

   versat_databus_arbiter #(.NUM_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(valid), .req_ready_o(req_ready_o),
      .req_addr_i(addr_p), .req_wdata_i(wdata_p), .req_wstrb_i(wstrb_p),
      .req_len_i(len_p), .req_write_i(wr),
      .req_rdata_o(req_rdata_o), .req_last_o(req_last_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_len_o(m_len_o),
      .m_write_o(m_write_o), .m_rdata_i(m_rdata), .m_last_i(m_last),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus, and where the next search starts.
   bit mbusy;
   int mown;
   int mptr;

   logic          exp_busy, exp_valid, exp_write;
   logic [1:0]    exp_grant;
   logic [N-1:0]  exp_ready, exp_last;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic [SW-1:0] exp_wstrb;
   logic [LW-1:0] exp_len;

   function automatic int pick(int base);
      for (int off = 0; off < N; off++) begin
         int k;
         k = (base + off) % N;
         if (valid[k]) return k;
      end
      return -1;
   endfunction

   task automatic sample();
      @(negedge clk);
      exp_busy  = mbusy;
      exp_grant = 2'(mown);
      if (mbusy) begin
         exp_valid = valid[mown];
         exp_addr  = a[mown];
         exp_wdata = wd[mown];
         exp_wstrb = ws[mown];
         exp_len   = ln[mown];
         exp_write = wr[mown];
         exp_ready = m_ready ? 4'(1 << mown) : 4'b0;
         exp_last  = m_last ? 4'(1 << mown) : 4'b0;
      end else begin
         exp_valid = 1'b0;
         exp_addr  = '0;
         exp_wdata = '0;
         exp_wstrb = '0;
         exp_len   = '0;
         exp_write = 1'b0;
         exp_ready = '0;
         exp_last  = '0;
      end
   endtask

   task automatic advance();
      bit rel;
      int w;
      rel = mbusy && valid[mown] && m_ready && m_last;
      if (!rst_n) begin
         mbusy = 0; mown = 0; mptr = 0;
      end else if (!mbusy) begin
         w = pick(mptr);
         if (w >= 0) begin mbusy = 1; mown = w; end
      end else if (rel) begin
         mptr  = (mown + 1) % N;
         mbusy = 0;
         if (B2B) begin
            w = pick(mptr);
            if (w >= 0) begin mbusy = 1; mown = w; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid = '0; m_ready = 1'b0; m_last = 1'b0;
      advance();
      advance();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 4'hF; m_ready = 1'b1; m_last = 1'b1; m_rdata = $urandom;
      advance();
      advance();
      sample();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy_o); end
      checks++; if (grant_o !== 2'd0) begin errors++; $display("FAIL reset_grant got %0h want 0", grant_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0h want 0", m_valid_o); end
      checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready got %0h want 0", req_ready_o); end
      checks++; if (req_last_o !== 4'b0) begin errors++; $display("FAIL reset_last got %0h want 0", req_last_o); end
      checks++; if (m_addr_o !== '0) begin errors++; $display("FAIL reset_m_addr got %0h want 0", m_addr_o); end
      checks++; if (req_rdata_o !== m_rdata) begin errors++; $display("FAIL reset_rdata got %0h want %0h", req_rdata_o, m_rdata); end
      rst_n = 1'b1; valid = '0; m_ready = 1'b0; m_last = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      a[2] = $urandom; wr = 4'b0100; ln[2] = 16'd4; m_ready = 1'b1; m_last = 1'b0;
      valid = 4'b0100;
      sample();
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency got %0h want 0", m_valid_o); end
      advance();
      for (int beat = 1; beat <= 4; beat++) begin
         wd[2] = $urandom;
         m_last = (beat == 4);
         sample();
         checks++; if (grant_o !== 2'd2) begin errors++; $display("FAIL single_grant got %0h want 2", grant_o); end
         checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0h want 1", m_valid_o); end
         checks++; if (m_wdata_o !== wd[2]) begin errors++; $display("FAIL single_wdata got %0h want %0h", m_wdata_o, wd[2]); end
         checks++; if (m_len_o !== 16'd4) begin errors++; $display("FAIL single_len got %0h want 4", m_len_o); end
         advance();
      end
      valid = '0; m_last = 1'b0;
      sample();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_release got %0h want 0", busy_o); end
      advance();
      valid = 4'b1001;
      advance();
      sample();
      checks++; if (grant_o !== 2'd3) begin errors++; $display("FAIL single_rr_ptr got %0h want 3", grant_o); end
   endtask

   task automatic test_fairness();
      int beat, grants, idle;
      int cyc;
      bit was_rel, pre_busy;
      logic [1:0] order [5];
      logic [1:0] want  [5];
      want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2; want[3] = 2'd3; want[4] = 2'd0;
      do_reset();
      valid = 4'hF; m_ready = 1'b1;
      beat = 0; grants = 0; idle = 0; cyc = 0;
      while (grants < 5 && cyc < 200) begin
         m_last = mbusy && (beat == 1);
         sample();
         if (mbusy) begin
            checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL fair_grant got %0h want %0h", grant_o, exp_grant); end
         end
         if (mbusy && beat == 0) begin
            order[grants] = grant_o;
            grants++;
         end else if (!busy_o && grants > 0) begin
            idle++;
         end
         if (grants < 5) begin
            pre_busy = mbusy;
            was_rel  = mbusy && m_last;
            advance();
            if (was_rel) beat = 0;
            else if (pre_busy) beat++;
         end
         cyc++;
      end
      checks++; if (grants != 5) begin errors++; $display("FAIL fair_timeout got %0d want 5", grants); end
      for (int i = 0; i < grants; i++) begin
         checks++; if (order[i] !== want[i]) begin errors++; $display("FAIL fair_order[%0d] got %0h want %0h", i, order[i], want[i]); end
      end
      checks++; if (idle != (B2B ? 0 : 4)) begin errors++; $display("FAIL fair_gap got %0d want %0d", idle, B2B ? 0 : 4); end
   endtask

   task automatic test_stall();
      do_reset();
      valid = 4'b0010; m_ready = 1'b0; m_last = 1'b0;
      advance();
      valid = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         sample();
         checks++; if (req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL stall_ready0 got %0h want 0", req_ready_o[0]); end
         checks++; if (grant_o !== 2'd1) begin errors++; $display("FAIL stall_grant got %0h want 1", grant_o); end
         advance();
      end
      m_ready = 1'b1; m_last = 1'b1;
      sample();
      checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL stall_accept got %0h want 2", req_ready_o); end
      advance();
      m_last = 1'b0;
      sample();
      checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL stall_post_busy got %0h want %0h", busy_o, exp_busy); end
      advance();
      sample();
      checks++; if (grant_o !== 2'd0) begin errors++; $display("FAIL stall_next_owner got %0h want 0", grant_o); end
   endtask

   task automatic test_spurious_last();
      do_reset();
      valid = 4'b0001; m_ready = 1'b0; m_last = 1'b0;
      advance();
      m_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL spur_busy got %0h want 1", busy_o); end
         checks++; if (req_last_o !== 4'b0001) begin errors++; $display("FAIL spur_last got %0h want 1", req_last_o); end
         advance();
      end
      valid = 4'b0000; m_ready = 1'b1;
      sample();
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL spur_novalid got %0h want 0", m_valid_o); end
      advance();
      sample();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL spur_hold got %0h want 1", busy_o); end
      valid = 4'b0001;
      advance();
      valid = 4'b0000; m_last = 1'b0;
      sample();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL spur_release got %0h want 0", busy_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      valid = 4'b1000; m_ready = 1'b1; m_last = 1'b0; ln[3] = 16'd6;
      advance();
      advance();
      rst_n = 1'b0;
      advance();
      sample();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0h want 0", busy_o); end
      checks++; if (grant_o !== 2'd0) begin errors++; $display("FAIL rstmid_grant got %0h want 0", grant_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0h want 0", m_valid_o); end
      rst_n = 1'b1; valid = 4'b1001;
      advance();
      sample();
      checks++; if (grant_o !== 2'd0) begin errors++; $display("FAIL rstmid_regrant got %0h want 0", grant_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_rebusy got %0h want 1", busy_o); end
   endtask

   task automatic test_isolation();
      do_reset();
      a[0] = 32'hDEADBEEF; a[2] = 32'hDEADBEEF; a[3] = 32'hDEADBEEF; a[1] = $urandom;
      valid = 4'b0010; m_ready = 1'b0; m_last = 1'b0;
      advance();
      for (int i = 0; i < 6; i++) begin
         a[1] = $urandom; m_ready = 1'b1; m_last = (i == 5);
         sample();
         checks++; if (m_addr_o !== a[1]) begin errors++; $display("FAIL iso_addr got %0h want %0h", m_addr_o, a[1]); end
         checks++; if ((req_last_o & 4'b1101) !== 4'b0) begin errors++; $display("FAIL iso_last got %0h want 0", req_last_o & 4'b1101); end
         checks++; if (req_last_o[1] !== m_last) begin errors++; $display("FAIL iso_own_last got %0h want %0h", req_last_o[1], m_last); end
         advance();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         valid = 4'($urandom);
         wr = 4'($urandom);
         for (int k = 0; k < N; k++) begin
            a[k] = $urandom; wd[k] = $urandom; ws[k] = 4'($urandom); ln[k] = 16'($urandom);
         end
         m_ready = 1'($urandom);
         m_last  = ($urandom_range(0, 2) == 0);
         m_rdata = $urandom;
         sample();
         checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL rnd_busy got %0h want %0h", busy_o, exp_busy); end
         checks++; if (grant_o !== exp_grant) begin errors++; $display("FAIL rnd_grant got %0h want %0h", grant_o, exp_grant); end
         checks++; if (m_valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid got %0h want %0h", m_valid_o, exp_valid); end
         checks++; if (m_addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr got %0h want %0h", m_addr_o, exp_addr); end
         checks++; if (m_wdata_o !== exp_wdata) begin errors++; $display("FAIL rnd_wdata got %0h want %0h", m_wdata_o, exp_wdata); end
         checks++; if (m_wstrb_o !== exp_wstrb) begin errors++; $display("FAIL rnd_wstrb got %0h want %0h", m_wstrb_o, exp_wstrb); end
         checks++; if (m_len_o !== exp_len) begin errors++; $display("FAIL rnd_len got %0h want %0h", m_len_o, exp_len); end
         checks++; if (m_write_o !== exp_write) begin errors++; $display("FAIL rnd_write got %0h want %0h", m_write_o, exp_write); end
         checks++; if (req_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready got %0h want %0h", req_ready_o, exp_ready); end
         checks++; if (req_last_o !== exp_last) begin errors++; $display("FAIL rnd_last got %0h want %0h", req_last_o, exp_last); end
         checks++; if (req_rdata_o !== m_rdata) begin errors++; $display("FAIL rnd_rdata got %0h want %0h", req_rdata_o, m_rdata); end
         advance();
      end
   endtask

   initial begin
      rst_n = 1'b0; valid = '0; wr = '0; m_ready = 1'b0; m_last = 1'b0; m_rdata = '0;
      for (int k = 0; k < N; k++) begin
         a[k] = '0; wd[k] = '0; ws[k] = '0; ln[k] = '0;
      end
      mbusy = 0; mown = 0; mptr = 0;
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_spurious_last();
      test_reset_mid();
      test_isolation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
